// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: scan states and active-high digit patterns.
package seg7_pkg;

  typedef enum logic [1:0] {GUARD0, SHOW0, GUARD1, SHOW1} scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_PAT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational digit-to-segment decoder with selectable output polarity.
module hex_to_seg7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_OFF;
    if (digit <= 4'd9) pat = SEG_PAT[digit];
    seg = ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/count_display_scan.sv
// Two-digit multiplexed display of a latched 0-15 count with guard slots,
// frame-aligned shadow updates and leading-zero blanking of the tens digit.
module count_display_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] value,
  input  logic       load,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [6:0]    SEG_IDLE   = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0]    AN_IDLE    = ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0]    AN_UNITS   = AN_IDLE ^ 2'b01;
  localparam logic [1:0]    AN_TENS    = AN_IDLE ^ 2'b10;

  scan_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    shadow, pend_val;
  logic          pend;
  logic          frame_end;
  logic          tens;
  logic [3:0]    units;
  logic [6:0]    seg_units, seg_tens, seg_d;
  logic [1:0]    an_d;

  assign frame_end = (state == SHOW1) && (cnt == CNT_LAST);
  assign tens      = (shadow >= 4'd10);
  assign units     = shadow - (tens ? 4'd10 : 4'd0);
  assign dp        = ACTIVE_LOW ? 1'b1 : 1'b0;

  hex_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_units (.digit(units), .seg(seg_units));
  hex_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_tens  (.digit({3'b000, tens}), .seg(seg_tens));

  // The slot counter spans guard plus show, so it only wraps on show exit.
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    case (state)
      GUARD0: if (cnt == GUARD_LAST) state_d = SHOW0;
      SHOW0:  if (cnt == CNT_LAST) begin state_d = GUARD1; cnt_d = '0; end
      GUARD1: if (cnt == GUARD_LAST) state_d = SHOW1;
      SHOW1:  if (cnt == CNT_LAST) begin state_d = GUARD0; cnt_d = '0; end
      default: begin state_d = GUARD0; cnt_d = '0; end
    endcase
  end

  always_comb begin
    an_d  = AN_IDLE;
    seg_d = SEG_IDLE;
    if (!blank) begin
      case (state)
        SHOW0: begin an_d = AN_UNITS; seg_d = seg_units; end
        SHOW1: if (tens) begin an_d = AN_TENS; seg_d = seg_tens; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GUARD0;
      cnt   <= '0;
      an    <= AN_IDLE;
      seg   <= SEG_IDLE;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      an    <= an_d;
      seg   <= seg_d;
    end
  end

  // A load landing on the frame boundary goes straight to the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
    end else begin
      if (load) pend_val <= value;
      if (frame_end) begin
        if (load)      shadow <= value;
        else if (pend) shadow <= pend_val;
        pend <= 1'b0;
      end else if (load) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_count_display_scan.sv
// Bench for count_display_scan: frame-position reference model, vector table,
// hand-written corner sequences and a randomized phase.
module tb_count_display_scan;

  localparam int RD = 8;
  localparam int GC = 2;
  localparam int FRAME = 2 * RD;

  logic       clk;
  logic       rst_n;
  logic [3:0] value;
  logic       load;
  logic       blank;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;

  count_display_scan #(.REFRESH_DIV(RD), .GUARD_CYCLES(GC), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank(blank),
    .seg(seg), .dp(dp), .an(an)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: frame position derived from edges since reset release
  logic [6:0] tb_pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         n_edges  = 0;
  int         m_shadow = 0;
  int         m_pval   = 0;
  bit         m_pend   = 0;
  logic [1:0] exp_an   = 2'b11;
  logic [6:0] exp_seg  = 7'h7F;

  always @(posedge clk or negedge rst_n) begin
    int pos, t, u;
    if (!rst_n) begin
      n_edges = 0; m_shadow = 0; m_pval = 0; m_pend = 0;
      exp_an = 2'b11; exp_seg = 7'h7F;
    end else begin
      pos = n_edges % FRAME;
      t = m_shadow / 10;
      u = m_shadow % 10;
      exp_an = 2'b11; exp_seg = 7'h7F;
      if (!blank && (pos % RD) >= GC) begin
        if (pos < RD) begin
          exp_an = 2'b10; exp_seg = ~tb_pat[u];
        end else if (t != 0) begin
          exp_an = 2'b01; exp_seg = ~tb_pat[t];
        end
      end
      if (pos == FRAME - 1) begin
        if (load) m_shadow = int'(value);
        else if (m_pend) m_shadow = m_pval;
        m_pend = 0;
      end else if (load) begin
        m_pval = int'(value);
        m_pend = 1;
      end
      n_edges++;
    end
  end

  // continuous scoreboard against the model
  always @(negedge clk) begin
    check("scan_an", {14'd0, an}, {14'd0, exp_an});
    check("scan_seg", {9'd0, seg}, {9'd0, exp_seg});
    check("dp_off", {15'd0, dp}, 16'd1);
    check("one_anode", {15'd0, an == 2'b00}, 16'd0);
  end

  // driver tasks
  task automatic goto_out(input int p);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (n_edges >= 1 && ((n_edges - 1) % FRAME) == p) return;
    end
    check("goto_out_timeout", 16'd1, 16'd0);
  endtask

  task automatic goto_drive(input int p);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if ((n_edges % FRAME) == p) return;
    end
    check("goto_drive_timeout", 16'd1, 16'd0);
  endtask

  task automatic pulse_load(input int p, input logic [3:0] v);
    goto_drive(p);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  typedef struct {
    logic [3:0] val;
    logic [6:0] units_seg;
    logic [1:0] tens_an;
    logic [6:0] tens_seg;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{4'd0,  7'h40, 2'b11, 7'h7F};
    vecs[1] = '{4'd7,  7'h78, 2'b11, 7'h7F};
    vecs[2] = '{4'd9,  7'h10, 2'b11, 7'h7F};
    vecs[3] = '{4'd10, 7'h40, 2'b01, 7'h79};
    vecs[4] = '{4'd13, 7'h30, 2'b01, 7'h79};
    vecs[5] = '{4'd15, 7'h12, 2'b01, 7'h79};

    rst_n = 1'b1; value = '0; load = 1'b0; blank = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_an", {14'd0, an}, 16'h0003);
    check("rst_seg", {9'd0, seg}, 16'h007F);
    check("rst_dp", {15'd0, dp}, 16'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle after reset: digit 0, tens blanked
    goto_out(0);  check("idle_guard_an", {14'd0, an}, 16'h0003);
    goto_out(4);  check("idle_units_an", {14'd0, an}, 16'h0002);
                  check("idle_units_seg", {9'd0, seg}, 16'h0040);
    goto_out(12); check("idle_tens_an", {14'd0, an}, 16'h0003);

    // load 13 mid-SHOW0: old value persists until the next frame
    pulse_load(5, 4'd13);
    goto_out(6);  check("no_tear_units", {9'd0, seg}, 16'h0040);
    goto_out(12); check("no_tear_tens_an", {14'd0, an}, 16'h0003);
    goto_out(4);  check("v13_units", {9'd0, seg}, 16'h0030);
    goto_out(12); check("v13_tens_an", {14'd0, an}, 16'h0001);
                  check("v13_tens_seg", {9'd0, seg}, 16'h0079);

    // table vectors
    for (int k = 0; k < 6; k++) begin
      pulse_load(5, vecs[k].val);
      goto_out(4);
      check($sformatf("vec%0d_units_an", k), {14'd0, an}, 16'h0002);
      check($sformatf("vec%0d_units_seg", k), {9'd0, seg}, {9'd0, vecs[k].units_seg});
      goto_out(12);
      check($sformatf("vec%0d_tens_an", k), {14'd0, an}, {14'd0, vecs[k].tens_an});
      check($sformatf("vec%0d_tens_seg", k), {9'd0, seg}, {9'd0, vecs[k].tens_seg});
    end

    // last of several loads in one frame wins
    pulse_load(3, 4'd5);
    pulse_load(6, 4'd9);
    pulse_load(9, 4'd12);
    goto_out(4);  check("latest_units", {9'd0, seg}, 16'h0024);
    goto_out(12); check("latest_tens", {9'd0, seg}, 16'h0079);

    // load on the boundary cycle goes straight to the shadow
    pulse_load(5, 4'd3);
    goto_drive(FRAME - 1);
    value = 4'd7; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("boundary_pend", {15'd0, dut.pend}, 16'd0);
    goto_out(4);  check("boundary_units", {9'd0, seg}, 16'h0078);
    goto_out(12); check("boundary_tens_an", {14'd0, an}, 16'h0003);

    // blank for 20 cycles
    goto_drive(6);
    blank = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("blank_an", {14'd0, an}, 16'h0003);
      check("blank_seg", {9'd0, seg}, 16'h007F);
    end
    blank = 1'b0;
    goto_out(4); check("unblank_units", {9'd0, seg}, 16'h0078);

    // async reset mid-SHOW1 with 15 displayed
    pulse_load(5, 4'd15);
    goto_out(4);
    goto_out(12); check("pre_rst_an", {14'd0, an}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_an", {14'd0, an}, 16'h0003);
    check("async_rst_seg", {9'd0, seg}, 16'h007F);
    @(negedge clk);
    rst_n = 1'b1;
    goto_out(4);  check("post_rst_units", {9'd0, seg}, 16'h0040);
    goto_out(12); check("post_rst_tens_an", {14'd0, an}, 16'h0003);

    // randomized phase, judged by the reference model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      load  = ($urandom_range(0, 7) == 0);
      value = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) blank = ~blank;
    end
    @(negedge clk);
    load = 1'b0; blank = 1'b0;
    repeat (2 * FRAME) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
